// File: rtl/ddr_app_pkg.sv
// Shared MIG command encodings, sequencer states and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package ddr_app_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } seq_state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_rd_return_fifo.sv
// First-word-fall-through FIFO holding MIG read data until the MCU takes it.
// Latency: a pushed word is visible on data_o the cycle after the push.
// Backpressure: none upstream; push while full is ignored unless a pop happens in the same cycle.
module ddr_rd_return_fifo
    import ddr_app_pkg::*;
#(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CW    = clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A pop frees the slot the push lands in, so push-at-full is fine then.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage array; contents are don't-care while the word is not counted.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ddr_app_sequencer.sv
// Splits MCU multi-beat requests into per-beat MIG app commands with auto-incrementing address.
// Latency: first app_en the cycle after acceptance; one beat per cycle when MIG is ready.
// Backpressure: follows app_rdy/app_wdf_rdy; reads issue only against free return-FIFO credits.
module ddr_app_sequencer
    import ddr_app_pkg::*;
#(
    parameter  int APP_ADDR_WIDTH = 28,
    parameter  int APP_DATA_WIDTH = 128,
    parameter  int MAX_BURST      = 16,
    parameter  int ADDR_STRIDE    = 8,
    parameter  int RD_FIFO_DEPTH  = 16,
    localparam int LEN_W          = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1,
    localparam int MASK_W         = APP_DATA_WIDTH / 8,
    localparam int CNT_W          = clog2(RD_FIFO_DEPTH) + 1
) (
    input  logic                      clk_166M66,
    input  logic                      mcu_sys_rst_n,
    input  logic                      i_init_calib_complete,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_rw,
    input  logic [APP_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_W-1:0]          i_req_len,
    input  logic [APP_DATA_WIDTH-1:0] i_wr_data,
    input  logic [MASK_W-1:0]         i_wr_mask,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    output logic [APP_DATA_WIDTH-1:0] o_rd_data,
    output logic                      o_rd_valid,
    input  logic                      i_rd_ready,
    output logic [APP_ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]                o_app_cmd,
    output logic                      o_app_en,
    input  logic                      i_app_rdy,
    output logic [APP_DATA_WIDTH-1:0] o_app_wdf_data,
    output logic [MASK_W-1:0]         o_app_wdf_mask,
    output logic                      o_app_wdf_wren,
    output logic                      o_app_wdf_end,
    input  logic                      i_app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] i_app_rd_data,
    input  logic                      i_app_rd_data_valid,
    output logic                      o_busy,
    output logic                      o_err
);

    seq_state_e                state_q, state_d;
    logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]          beats_q, beats_d;
    logic [2:0]                cmd_q, cmd_d;
    logic                      cmd_done_q, cmd_done_d;
    logic                      data_done_q, data_done_d;
    logic [CNT_W-1:0]          outstanding_q, outstanding_d;
    logic                      err_q, err_d;
    logic                      alive_q;

    logic                      req_ready;
    logic                      app_en;
    logic                      wren;
    logic                      wr_ready;
    logic                      rd_issue;
    logic [CNT_W-1:0]          credits;
    logic                      rd_beat_ok;
    logic                      rd_overflow;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [CNT_W-1:0]          fifo_count;
    logic [APP_DATA_WIDTH-1:0] fifo_dout;

    // Every slot is either occupied, or promised to a read already sent to MIG.
    assign credits = CNT_W'(RD_FIFO_DEPTH) - fifo_count - outstanding_q;

    // Request sequencing: beat address/count bookkeeping and MIG handshake outputs.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        beats_d        = beats_q;
        cmd_d          = cmd_q;
        cmd_done_d     = cmd_done_q;
        data_done_d    = data_done_q;
        req_ready      = 1'b0;
        app_en         = 1'b0;
        wren           = 1'b0;
        wr_ready       = 1'b0;
        rd_issue       = 1'b0;
        o_app_wdf_data = '0;
        o_app_wdf_mask = '0;
        unique case (state_q)
            IDLE: begin
                // alive_q holds ready low while reset is asserted and for the first edge after.
                req_ready = alive_q & i_init_calib_complete;
                if (i_req_valid && req_ready) begin
                    addr_d      = i_req_addr;
                    beats_d     = i_req_len;
                    cmd_d       = i_req_rw ? APP_CMD_WRITE : APP_CMD_READ;
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    state_d     = i_req_rw ? WRITE : READ;
                end
            end
            WRITE: begin
                app_en         = ~cmd_done_q;
                wren           = ~data_done_q & i_wr_valid;
                wr_ready       = ~data_done_q & i_app_wdf_rdy;
                o_app_wdf_data = i_wr_data;
                o_app_wdf_mask = i_wr_mask;
                // Command and data halves may finish in either order or together.
                if ((cmd_done_q | (app_en & i_app_rdy)) && (data_done_q | (wren & i_app_wdf_rdy))) begin
                    addr_d      = addr_q + APP_ADDR_WIDTH'(ADDR_STRIDE);
                    beats_d     = beats_q - LEN_W'(1);
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    if (beats_q == '0) state_d = IDLE;
                end else begin
                    cmd_done_d  = cmd_done_q | (app_en & i_app_rdy);
                    data_done_d = data_done_q | (wren & i_app_wdf_rdy);
                end
            end
            READ: begin
                app_en   = (credits != '0);
                rd_issue = app_en & i_app_rdy;
                // Leave as soon as the last command is taken; data drains in the background.
                if (rd_issue) begin
                    addr_d  = addr_q + APP_ADDR_WIDTH'(ADDR_STRIDE);
                    beats_d = beats_q - LEN_W'(1);
                    if (beats_q == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return accounting: MIG data cannot stall, so unexpected or unroomed beats are dropped and flagged.
    always_comb begin
        rd_beat_ok    = i_app_rd_data_valid & (outstanding_q != '0);
        rd_overflow   = rd_beat_ok & fifo_full & ~fifo_pop;
        fifo_push     = rd_beat_ok & ~rd_overflow;
        outstanding_d = outstanding_q + CNT_W'(rd_issue) - CNT_W'(rd_beat_ok);
        err_d         = err_q | (i_app_rd_data_valid & (outstanding_q == '0)) | rd_overflow;
    end

    // State and counters.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            beats_q       <= '0;
            cmd_q         <= APP_CMD_WRITE;
            cmd_done_q    <= 1'b0;
            data_done_q   <= 1'b0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            alive_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            cmd_q         <= cmd_d;
            cmd_done_q    <= cmd_done_d;
            data_done_q   <= data_done_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            alive_q       <= 1'b1;
        end
    end

    assign fifo_pop = ~fifo_empty & i_rd_ready;

    ddr_rd_return_fifo #(
        .WIDTH (APP_DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i   (clk_166M66),
        .rst_n_i (mcu_sys_rst_n),
        .push_i  (fifo_push),
        .data_i  (i_app_rd_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign o_req_ready    = req_ready;
    assign o_app_en       = app_en;
    assign o_app_wdf_wren = wren;
    assign o_app_wdf_end  = wren;
    assign o_wr_ready     = wr_ready;
    assign o_app_addr     = addr_q;
    assign o_app_cmd      = cmd_q;
    assign o_rd_valid     = ~fifo_empty;
    assign o_rd_data      = fifo_empty ? '0 : fifo_dout;
    assign o_busy         = (state_q != IDLE) | (outstanding_q != '0);
    assign o_err          = err_q;

endmodule

// File: tb/tb_ddr_app_sequencer.sv
// Directed bench for ddr_app_sequencer: drives MCU and MIG sides, checks handshakes and data order.
// Latency: n/a.
// Backpressure: MIG ready signals and the read consumer are toggled per scenario.
module tb_ddr_app_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         calib;
    logic         i_req_valid, o_req_ready, i_req_rw;
    logic [27:0]  i_req_addr;
    logic [3:0]   i_req_len;
    logic [127:0] i_wr_data;
    logic [15:0]  i_wr_mask;
    logic         i_wr_valid, o_wr_ready;
    logic [127:0] o_rd_data;
    logic         o_rd_valid, i_rd_ready;
    logic [27:0]  o_app_addr;
    logic [2:0]   o_app_cmd;
    logic         o_app_en, i_app_rdy;
    logic [127:0] o_app_wdf_data;
    logic [15:0]  o_app_wdf_mask;
    logic         o_app_wdf_wren, o_app_wdf_end, i_app_wdf_rdy;
    logic [127:0] i_app_rd_data;
    logic         i_app_rd_data_valid;
    logic         o_busy, o_err;

    int checks = 0;
    int errors = 0;

    logic [27:0]  mon_addr[$];
    logic [2:0]   mon_cmd[$];
    logic [127:0] mon_wdf[$];
    logic [15:0]  mon_mask[$];
    logic         mon_end[$];
    logic [127:0] mon_pop[$];

    always #3 clk = ~clk;

    ddr_app_sequencer dut (
        .clk_166M66            (clk),
        .mcu_sys_rst_n         (rst_n),
        .i_init_calib_complete (calib),
        .i_req_valid           (i_req_valid),
        .o_req_ready           (o_req_ready),
        .i_req_rw              (i_req_rw),
        .i_req_addr            (i_req_addr),
        .i_req_len             (i_req_len),
        .i_wr_data             (i_wr_data),
        .i_wr_mask             (i_wr_mask),
        .i_wr_valid            (i_wr_valid),
        .o_wr_ready            (o_wr_ready),
        .o_rd_data             (o_rd_data),
        .o_rd_valid            (o_rd_valid),
        .i_rd_ready            (i_rd_ready),
        .o_app_addr            (o_app_addr),
        .o_app_cmd             (o_app_cmd),
        .o_app_en              (o_app_en),
        .i_app_rdy             (i_app_rdy),
        .o_app_wdf_data        (o_app_wdf_data),
        .o_app_wdf_mask        (o_app_wdf_mask),
        .o_app_wdf_wren        (o_app_wdf_wren),
        .o_app_wdf_end         (o_app_wdf_end),
        .i_app_wdf_rdy         (i_app_wdf_rdy),
        .i_app_rd_data         (i_app_rd_data),
        .i_app_rd_data_valid   (i_app_rd_data_valid),
        .o_busy                (o_busy),
        .o_err                 (o_err)
    );

    function automatic logic [127:0] wpat(input int i);
        return {32'hDA7A_0000 + 32'(i), 32'h1111_1111 * 32'(i + 1), 32'hFACE_0000 | 32'(i), 32'(i)};
    endfunction

    function automatic logic [127:0] rpat(input int i);
        return {4{32'hBEEF_0000 + 32'(i)}};
    endfunction

    // Record every MIG-side and consumer-side handshake mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_app_en && i_app_rdy) begin
                mon_addr.push_back(o_app_addr);
                mon_cmd.push_back(o_app_cmd);
            end
            if (o_app_wdf_wren && i_app_wdf_rdy) begin
                mon_wdf.push_back(o_app_wdf_data);
                mon_mask.push_back(o_app_wdf_mask);
                mon_end.push_back(o_app_wdf_end);
            end
            if (o_rd_valid && i_rd_ready) mon_pop.push_back(o_rd_data);
        end
    end

    task automatic clear_mon();
        mon_addr.delete(); mon_cmd.delete(); mon_wdf.delete();
        mon_mask.delete(); mon_end.delete(); mon_pop.delete();
    endtask

    // Present a request from posedge+1 and return at posedge+1 just after it was accepted.
    task automatic send_req(input logic rw, input logic [27:0] addr, input logic [3:0] len);
        bit got;
        got = 1'b0;
        i_req_rw = rw; i_req_addr = addr; i_req_len = len; i_req_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = o_req_ready;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL req_accept: o_req_ready never high, got 0 want 1 (addr %h)", addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; calib = 1'b1;
        i_req_valid = 0; i_req_rw = 0; i_req_addr = '0; i_req_len = '0;
        i_wr_data = '0; i_wr_mask = '0; i_wr_valid = 0; i_rd_ready = 0;
        i_app_rdy = 0; i_app_wdf_rdy = 0; i_app_rd_data = '0; i_app_rd_data_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", o_req_ready); end
        checks++; if (o_app_cmd !== 3'b000) begin errors++; $display("FAIL reset_app_cmd: got %b want 000", o_app_cmd); end
        checks++; if (o_app_en !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 || o_rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: en=%b busy=%b err=%b rdv=%b want all 0", o_app_en, o_busy, o_err, o_rd_valid); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", o_req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        int widx, idle_k;
        logic fire;
        clear_mon();
        i_app_rdy = 1; i_app_wdf_rdy = 1;
        widx = 0; idle_k = 0;
        i_wr_valid = 1; i_wr_data = wpat(0); i_wr_mask = 16'h0001;
        send_req(1'b1, 28'h0000100, 4'd3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            fire = o_wr_ready & i_wr_valid;
            if (o_req_ready && idle_k == 0) idle_k = k;
            @(posedge clk); #1;
            if (fire) begin
                widx++;
                i_wr_data = wpat(widx);
                i_wr_mask = 16'h0001 << widx;
                i_wr_valid = (widx <= 3);
            end
        end
        checks++; if (idle_k != 5) begin errors++; $display("FAIL wr_idle_cycle: got %0d want 5", idle_k); end
        checks++; if (mon_addr.size() != 4 || mon_wdf.size() != 4) begin
            errors++; $display("FAIL wr_beat_count: cmds %0d wdf %0d want 4 4", mon_addr.size(), mon_wdf.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < mon_addr.size()) begin
                checks++; if (mon_addr[i] !== 28'h100 + 28'(8 * i) || mon_cmd[i] !== 3'b000) begin
                    errors++; $display("FAIL wr_cmd%0d: addr %h cmd %b want %h 000", i, mon_addr[i], mon_cmd[i], 28'h100 + 28'(8 * i)); end
            end
            if (i < mon_wdf.size()) begin
                checks++; if (mon_wdf[i] !== wpat(i) || mon_end[i] !== 1'b1 || mon_mask[i] !== (16'h0001 << i)) begin
                    errors++; $display("FAIL wr_data%0d: data %h end %b mask %h want %h 1 %h", i, mon_wdf[i], mon_end[i], mon_mask[i], wpat(i), 16'h0001 << i); end
            end
        end
    endtask

    task automatic test_write_stall();
        int widx, idle_k;
        logic fire;
        logic wrr_log[1:10];
        logic en_log[1:10];
        logic wren_log[1:10];
        clear_mon();
        i_app_rdy = 0; i_app_wdf_rdy = 1;
        widx = 0; idle_k = 0;
        i_wr_valid = 1; i_wr_data = wpat(0); i_wr_mask = 16'h0;
        send_req(1'b1, 28'h0000200, 4'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            wrr_log[k] = o_wr_ready; en_log[k] = o_app_en; wren_log[k] = o_app_wdf_wren;
            fire = o_wr_ready & i_wr_valid;
            if (o_req_ready && idle_k == 0) idle_k = k;
            @(posedge clk); #1;
            i_app_rdy = (k + 1 >= 4);
            if (fire) begin
                widx++;
                i_wr_data = wpat(widx);
                i_wr_valid = (widx <= 1);
            end
        end
        checks++; if (wrr_log[1] !== 1'b1) begin errors++; $display("FAIL stall_data_first: wr_ready got %b want 1", wrr_log[1]); end
        checks++; if (wrr_log[2] !== 1'b0 || wrr_log[3] !== 1'b0 || wrr_log[4] !== 1'b0) begin
            errors++; $display("FAIL stall_wr_ready_low: got %b%b%b want 000", wrr_log[2], wrr_log[3], wrr_log[4]); end
        checks++; if (en_log[3] !== 1'b1 || wren_log[2] !== 1'b0) begin
            errors++; $display("FAIL stall_en_wren: app_en %b wren %b want 1 0", en_log[3], wren_log[2]); end
        checks++; if (wrr_log[5] !== 1'b1) begin errors++; $display("FAIL stall_second_beat: wr_ready got %b want 1", wrr_log[5]); end
        checks++; if (idle_k != 6) begin errors++; $display("FAIL stall_idle_cycle: got %0d want 6", idle_k); end
        checks++; if (mon_addr.size() != 2 || mon_wdf.size() != 2) begin
            errors++; $display("FAIL stall_counts: cmds %0d wdf %0d want 2 2", mon_addr.size(), mon_wdf.size());
        end else if (mon_addr[0] !== 28'h200 || mon_addr[1] !== 28'h208 || mon_wdf[0] !== wpat(0) || mon_wdf[1] !== wpat(1)) begin
            errors++; $display("FAIL stall_order: addr %h %h want 200 208, data0 ok %b data1 ok %b", mon_addr[0], mon_addr[1], mon_wdf[0] === wpat(0), mon_wdf[1] === wpat(1));
        end
    endtask

    task automatic test_read_credits();
        int ret_at[$];
        int ret_idx, stall_bad;
        clear_mon();
        i_app_rdy = 1; i_rd_ready = 0; i_wr_valid = 0;
        ret_idx = 0; stall_bad = 0;
        send_req(1'b0, 28'h0001000, 4'd15);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (o_app_en && i_app_rdy) ret_at.push_back(k + 10);
            if (k >= 18 && k <= 40 && o_app_en) stall_bad++;
            if (k == 17) begin
                checks++; if (mon_addr.size() != 16) begin errors++; $display("FAIL rd_first_burst_cmds: got %0d want 16", mon_addr.size()); end
                checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rd_idle_after_issue: req_ready %b want 1", o_req_ready); end
            end
            if (k == 40) begin
                checks++; if (stall_bad != 0 || mon_addr.size() != 16) begin
                    errors++; $display("FAIL rd_credit_stall: app_en cycles %0d cmds %0d want 0 16", stall_bad, mon_addr.size()); end
                checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== rpat(0)) begin
                    errors++; $display("FAIL rd_fwft_head: valid %b data %h want 1 %h", o_rd_valid, o_rd_data, rpat(0)); end
                checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rd_no_err: got %b want 0", o_err); end
            end
            if (k == 41) begin
                checks++; if (o_app_en !== 1'b1 || o_app_addr !== 28'h0002000) begin
                    errors++; $display("FAIL rd_issue_after_pop: en %b addr %h want 1 2000", o_app_en, o_app_addr); end
            end
            @(posedge clk); #1;
            i_req_valid = (k + 1 == 17);
            i_req_rw = 1'b0; i_req_addr = 28'h0002000; i_req_len = 4'd0;
            i_rd_ready = (k + 1 == 40) || (k + 1 >= 60);
            i_app_rd_data_valid = 1'b0;
            if (ret_at.size() > 0 && ret_at[0] == k + 1) begin
                void'(ret_at.pop_front());
                i_app_rd_data_valid = 1'b1;
                i_app_rd_data = rpat(ret_idx);
                ret_idx++;
            end
        end
        i_rd_ready = 0;
        checks++; if (mon_addr.size() != 17) begin
            errors++; $display("FAIL rd_total_cmds: got %0d want 17", mon_addr.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (mon_addr[i] !== 28'h1000 + 28'(8 * i) || mon_cmd[i] !== 3'b001) begin
                    errors++; $display("FAIL rd_cmd%0d: addr %h cmd %b want %h 001", i, mon_addr[i], mon_cmd[i], 28'h1000 + 28'(8 * i)); end
            end
        end
        checks++; if (mon_pop.size() != 17) begin
            errors++; $display("FAIL rd_pop_count: got %0d want 17", mon_pop.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++; if (mon_pop[i] !== rpat(i)) begin errors++; $display("FAIL rd_pop%0d: got %h want %h", i, mon_pop[i], rpat(i)); end
            end
        end
        checks++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL rd_final: busy %b err %b want 0 0", o_busy, o_err); end
    endtask

    task automatic test_unexpected_data();
        @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL unexp_pre: err %b rdv %b want 0 0", o_err, o_rd_valid); end
        @(posedge clk); #1 i_app_rd_data_valid = 1'b1; i_app_rd_data = rpat(99);
        @(posedge clk); #1 i_app_rd_data_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL unexp_err_set: got %b want 1", o_err); end
        checks++; if (o_rd_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL unexp_dropped: rdv %b busy %b want 0 0", o_rd_valid, o_busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL unexp_err_sticky: got %b want 1", o_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        int widx;
        logic fire;
        clear_mon();
        i_app_rdy = 1; i_app_wdf_rdy = 1;
        widx = 0; i_wr_valid = 1; i_wr_data = wpat(0);
        send_req(1'b1, 28'h0000300, 4'd7);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            fire = o_wr_ready & i_wr_valid;
            @(posedge clk); #1;
            if (fire) begin widx++; i_wr_data = wpat(widx); end
        end
        checks++; if (mon_wdf.size() != 3) begin errors++; $display("FAIL rstw_beats_before: got %0d want 3", mon_wdf.size()); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_app_en !== 1'b0 || o_app_wdf_wren !== 1'b0 || o_wr_ready !== 1'b0 || o_req_ready !== 1'b0) begin
            errors++; $display("FAIL rstw_handshakes: en %b wren %b wrr %b reqr %b want 0000", o_app_en, o_app_wdf_wren, o_wr_ready, o_req_ready); end
        checks++; if (o_app_addr !== 28'h0 || o_app_wdf_data !== 128'h0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("FAIL rstw_values: addr %h data %h busy %b err %b want 0", o_app_addr, o_app_wdf_data, o_busy, o_err); end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready_after: got %b want 1", o_req_ready); end
        @(posedge clk); #1;
        i_wr_data = wpat(7); i_wr_valid = 1;
        send_req(1'b1, 28'h0000400, 4'd0);
        repeat (4) @(posedge clk);
        #1 i_wr_valid = 0;
        checks++; if (mon_addr.size() != 1 || mon_wdf.size() != 1) begin
            errors++; $display("FAIL rstw_new_req_count: cmds %0d wdf %0d want 1 1", mon_addr.size(), mon_wdf.size());
        end else if (mon_addr[0] !== 28'h400 || mon_wdf[0] !== wpat(7)) begin
            errors++; $display("FAIL rstw_new_req: addr %h want 400, data ok %b", mon_addr[0], mon_wdf[0] === wpat(7));
        end
    endtask

    task automatic test_addr_wrap();
        clear_mon();
        i_app_rdy = 1; i_rd_ready = 1;
        send_req(1'b0, 28'hFFFFFF8, 4'd1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (mon_addr.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d want 2", mon_addr.size());
        end else begin
            checks++; if (mon_addr[0] !== 28'hFFFFFF8 || mon_addr[1] !== 28'h0000000) begin
                errors++; $display("FAIL wrap_addr: got %h %h want FFFFFF8 0000000", mon_addr[0], mon_addr[1]); end
        end
        i_app_rd_data_valid = 1; i_app_rd_data = rpat(0);
        @(posedge clk); #1 i_app_rd_data = rpat(1);
        @(posedge clk); #1 i_app_rd_data_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mon_pop.size() != 2 || o_err !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL wrap_return: pops %0d err %b busy %b want 2 0 0", mon_pop.size(), o_err, o_busy); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_stall();
        test_read_credits();
        test_unexpected_data();
        test_reset_mid_write();
        test_addr_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
